// File: rtl/adder_rr_arbiter.sv
// Purpose : one shared N-bit adder (sum + carry-out) time-shared round-robin among R requesters.
// Latency : a pair granted in cycle t appears on rsp_* in cycle t+1; one result per cycle sustained.
// Backpressure: a single result register; when it is held (rsp_ready=0), no request is granted.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b          packed operands, requester i at bits [i*N +: N]
//   rsp_valid/rsp_ready   result handshake
//   rsp_sum, rsp_cout     registered (a+b) mod 2^N and carry-out
//   rsp_id                requester that produced the held result
//   op_count              saturating count of accepted requests
module adder_rr_arbiter #(
    parameter int N    = 32,
    parameter int R    = 4,
    parameter int IDW  = $clog2(R),
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [R-1:0]    req_valid,
    output logic [R-1:0]    req_ready,
    input  logic [R*N-1:0]  req_a,
    input  logic [R*N-1:0]  req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [N-1:0]    rsp_sum,
    output logic            rsp_cout,
    output logic [IDW-1:0]  rsp_id,
    output logic [CNTW-1:0] op_count
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t          r_state;
    logic [N-1:0]    r_sum;
    logic            r_cout;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  r_rr_ptr;
    logic [CNTW-1:0] r_op_count;

    logic            w_slot_free;
    logic            w_found;
    logic            w_grant;
    logic [IDW-1:0]  w_gnt_id;
    logic [IDW-1:0]  w_ptr_next;
    logic [N-1:0]    w_a;
    logic [N-1:0]    w_b;
    logic [N:0]      w_sum;

    // The slot can take a new result when empty or when the held one is
    // leaving this cycle. Gated by rst so nothing is offered during reset.
    assign w_slot_free = !rst && ((r_state == ST_EMPTY) || rsp_ready);

    // Rotating priority search starting at r_rr_ptr, wrapping at R (not 2^IDW).
    always_comb begin
        int v_idx;
        w_found  = 1'b0;
        w_gnt_id = '0;
        v_idx    = 0;
        for (int k = 0; k < R; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % R;
            if (!w_found && req_valid[v_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = v_idx[IDW-1:0];
            end
        end
    end

    assign w_grant = w_slot_free && w_found;

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_a        = req_a[w_gnt_id*N +: N];
    assign w_b        = req_b[w_gnt_id*N +: N];
    assign w_sum      = {1'b0, w_a} + {1'b0, w_b};
    assign w_ptr_next = (w_gnt_id == IDW'(R-1)) ? '0 : w_gnt_id + 1'b1;

    // A grant always lands in the slot (it is free by construction), which
    // also covers the drain-and-refill case; otherwise a drain empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_id       <= '0;
            r_rr_ptr   <= '0;
            r_op_count <= '0;
        end else begin
            if (w_grant) begin
                r_state           <= ST_FULL;
                {r_cout, r_sum}   <= w_sum;
                r_id              <= w_gnt_id;
                r_rr_ptr          <= w_ptr_next;
                if (r_op_count != '1) begin
                    r_op_count <= r_op_count + 1'b1;
                end
            end else if ((r_state == ST_FULL) && rsp_ready) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;
    localparam int N    = 32;
    localparam int R    = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [R-1:0]    req_valid;
    logic [R-1:0]    req_ready;
    logic [R*N-1:0]  req_a;
    logic [R*N-1:0]  req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [N-1:0]    rsp_sum;
    logic            rsp_cout;
    logic [IDW-1:0]  rsp_id;
    logic [CNTW-1:0] op_count;

    adder_rr_arbiter #(.N(N), .R(R), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [N-1:0] a_v [R];
    logic [N-1:0] b_v [R];

    // Reference model: plain integers for the slot, result, pointer and count.
    bit          m_full;
    logic [N:0]  m_res;
    int          m_id;
    int          m_ptr;
    int          m_cnt;
    int          last_g;
    logic [N-1:0] held_sum;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_res  = '0;
        m_id   = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    function automatic int model_grant();
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < R; k++) begin
            if (req_valid[(m_ptr + k) % R]) return (m_ptr + k) % R;
        end
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < R; i++) begin
            req_a[i*N +: N] = a_v[i];
            req_b[i*N +: N] = b_v[i];
        end
    endtask

    // Called at a negedge with inputs already set; ends at the next negedge.
    task automatic step(input string tag);
        int g;
        logic [R-1:0] exp_rdy;
        pack();
        #1;
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check({tag, " req_ready"}, 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        if (g >= 0) begin
            m_full = 1'b1;
            m_res  = {1'b0, a_v[g]} + {1'b0, b_v[g]};
            m_id   = g;
            m_ptr  = (g + 1) % R;
            if (m_cnt < CMAX) m_cnt++;
        end else if (rsp_ready) begin
            m_full = 1'b0;
        end
        last_g = g;
        #1;
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(m_full));
        check({tag, " op_count"}, 64'(op_count), 64'(m_cnt));
        if (m_full) begin
            check({tag, " rsp_sum"}, 64'(rsp_sum), 64'(m_res[N-1:0]));
            check({tag, " rsp_cout"}, 64'(rsp_cout), 64'(m_res[N]));
            check({tag, " rsp_id"}, 64'(rsp_id), 64'(m_id));
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 64'(req_ready), 64'(0));
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, " op_count"}, 64'(op_count), 64'(0));
        check({tag, " rsp_sum"}, 64'({rsp_cout, rsp_sum}), 64'(0));
        check({tag, " rsp_id"}, 64'(rsp_id), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_a");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_b");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < R; i++) begin
            a_v[i] = $urandom;
            b_v[i] = $urandom;
        end
        pack();
        model_reset();
        @(negedge clk);

        // Reset with every requester asking; first grant after release is 0.
        do_reset();
        step("first");
        check("first id", 64'(rsp_id), 64'(0));

        // Lone requester 2 with a carry-producing pair.
        req_valid = 4'b0100;
        a_v[2] = 32'hFFFF_FFFF;
        b_v[2] = 32'h0000_0001;
        step("carry");
        check("carry sum", 64'(rsp_sum), 64'(0));
        check("carry cout", 64'(rsp_cout), 64'(1));
        check("carry id", 64'(rsp_id), 64'(2));

        // All four continuously valid from a fresh pointer: 0,1,2,3,0.
        do_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < R; i++) begin
                a_v[i] = $urandom;
                b_v[i] = $urandom;
            end
            step("rr");
            check("rr id", 64'(rsp_id), 64'(k % R));
            check("rr count", 64'(op_count), 64'(k + 1));
        end

        // Hold the result for 3 cycles with requester 1 waiting.
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        a_v[1] = $urandom;
        b_v[1] = $urandom;
        held_sum = rsp_sum;
        for (int k = 0; k < 3; k++) begin
            step("hold");
            check("hold sum", 64'(rsp_sum), 64'(held_sum));
        end
        rsp_ready = 1'b1;
        step("release");
        check("release id", 64'(rsp_id), 64'(1));
        req_valid = '0;

        // Requester 3 alone, then 0 and 3: pointer wrap favours 0.
        req_valid = 4'b1000;
        step("wrap3");
        check("wrap3 id", 64'(rsp_id), 64'(3));
        req_valid = 4'b1001;
        step("wrap0");
        check("wrap0 id", 64'(rsp_id), 64'(0));
        req_valid = 4'b1000;
        step("wrap3b");
        check("wrap3b id", 64'(rsp_id), 64'(3));

        // Asynchronous reset mid-cycle while a result is held.
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        step("pre_arst");
        check("pre_arst valid", 64'(rsp_valid), 64'(1));
        req_valid = '1;
        #2;
        rst = 1'b1;
        #1;
        check("arst valid", 64'(rsp_valid), 64'(0));
        check("arst count", 64'(op_count), 64'(0));
        check("arst ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rsp_ready = 1'b1;
        step("post_arst");
        check("post_arst id", 64'(rsp_id), 64'(0));

        // Randomised traffic honouring the hold-until-ready contract.
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < R; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    a_v[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    b_v[i] = $urandom;
                end
            end
            step("rnd");
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
